// File: rtl/npu_pkg.sv
// Shared types and capacities for the NPU memory-block loaders.
package npu_pkg;

    localparam int unsigned IMG_CAP   = 4096;
    localparam int unsigned CONV_CAP  = 32768;
    localparam int unsigned DENSE_CAP = 32768;

    typedef enum logic [1:0] {
        TGT_IMAGE,
        TGT_CONV,
        TGT_DENSE,
        TGT_DENSEB
    } tgt_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_e;

    // Byte capacity of a load target.
    function automatic logic [15:0] tgt_cap(input tgt_e t);
        case (t)
            TGT_IMAGE: return 16'(IMG_CAP);
            TGT_CONV:  return 16'(CONV_CAP);
            default:   return 16'(DENSE_CAP);
        endcase
    endfunction

endpackage

// File: rtl/npu_mem_loader.sv
// Write-side loader: turns a load command plus a byte stream into RAM write
// pulses. Image bytes are striped across four banks (bank = cnt[1:0]).
module npu_mem_loader
    import npu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_target,
    input  logic [15:0] cmd_len,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic [9:0]  image_ram_addr_a,
    output logic [7:0]  data_image0,
    output logic [7:0]  data_image1,
    output logic [7:0]  data_image2,
    output logic [7:0]  data_image3,
    output logic        we_image0,
    output logic        we_image1,
    output logic        we_image2,
    output logic        we_image3,
    output logic [14:0] conv_ram_addr_a,
    output logic [7:0]  data_conv,
    output logic        we_conv,
    output logic [14:0] dense_ram_addr_a,
    output logic [7:0]  data_dense,
    output logic        we_dense,
    output logic [14:0] denseb_ram_addr_a,
    output logic [7:0]  data_denseb,
    output logic        we_denseb,
    output logic        busy,
    output logic        done,
    output logic        len_err
);

    state_e      state, state_nx;
    tgt_e        tgt;
    logic [15:0] len_eff;
    logic [15:0] cnt;
    logic [15:0] cap;
    logic [15:0] len_clip;
    logic        cmd_acc;
    logic        byte_acc;
    logic        last_byte;

    logic [7:0]  data_img [4];
    logic [3:0]  we_img;

    assign cmd_ready = (state == IDLE);
    assign in_ready  = (state == LOAD);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    assign cap       = tgt_cap(tgt_e'(cmd_target));
    assign len_clip  = (cmd_len > cap) ? cap : cmd_len;
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign byte_acc  = in_valid && in_ready;
    // len_eff is nonzero whenever LOAD is entered, so the subtraction never wraps here.
    assign last_byte = byte_acc && (cnt == len_eff - 16'd1);

    assign data_image0 = data_img[0];
    assign data_image1 = data_img[1];
    assign data_image2 = data_img[2];
    assign data_image3 = data_img[3];
    assign we_image0   = we_img[0];
    assign we_image1   = we_img[1];
    assign we_image2   = we_img[2];
    assign we_image3   = we_img[3];

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; a zero-length command skips LOAD entirely.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (cmd_acc) state_nx = (len_clip == '0) ? DONE : LOAD;
            LOAD: if (last_byte) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Command latch, clipped length, sticky length error and byte counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tgt     <= TGT_IMAGE;
            len_eff <= '0;
            cnt     <= '0;
            len_err <= 1'b0;
        end else if (cmd_acc) begin
            tgt     <= tgt_e'(cmd_target);
            len_eff <= len_clip;
            len_err <= (cmd_len > cap);
            cnt     <= '0;
        end else if (byte_acc) begin
            cnt <= cnt + 16'd1;
        end
    end

    // Registered write ports: one-cycle pulse per accepted byte; addr/data hold otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            image_ram_addr_a  <= '0;
            we_img            <= '0;
            for (int unsigned i = 0; i < 4; i++) data_img[i] <= '0;
            conv_ram_addr_a   <= '0;
            data_conv         <= '0;
            we_conv           <= 1'b0;
            dense_ram_addr_a  <= '0;
            data_dense        <= '0;
            we_dense          <= 1'b0;
            denseb_ram_addr_a <= '0;
            data_denseb       <= '0;
            we_denseb         <= 1'b0;
        end else begin
            we_img    <= '0;
            we_conv   <= 1'b0;
            we_dense  <= 1'b0;
            we_denseb <= 1'b0;
            if (byte_acc) begin
                case (tgt)
                    TGT_IMAGE: begin
                        image_ram_addr_a   <= cnt[11:2];
                        we_img[cnt[1:0]]   <= 1'b1;
                        data_img[cnt[1:0]] <= in_data;
                    end
                    TGT_CONV: begin
                        conv_ram_addr_a <= cnt[14:0];
                        data_conv       <= in_data;
                        we_conv         <= 1'b1;
                    end
                    TGT_DENSE: begin
                        dense_ram_addr_a <= cnt[14:0];
                        data_dense       <= in_data;
                        we_dense         <= 1'b1;
                    end
                    default: begin
                        denseb_ram_addr_a <= cnt[14:0];
                        data_denseb       <= in_data;
                        we_denseb         <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_npu_mem_loader.sv
// Self-checking bench for npu_mem_loader: writes are predicted into a
// scoreboard when a byte is accepted and matched when the we pulse appears.
module tb_npu_mem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_target = '0;
    logic [15:0] cmd_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [9:0]  image_ram_addr_a;
    logic [7:0]  data_image0, data_image1, data_image2, data_image3;
    logic        we_image0, we_image1, we_image2, we_image3;
    logic [14:0] conv_ram_addr_a, dense_ram_addr_a, denseb_ram_addr_a;
    logic [7:0]  data_conv, data_dense, data_denseb;
    logic        we_conv, we_dense, we_denseb;
    logic        busy, done, len_err;

    npu_mem_loader dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .image_ram_addr_a(image_ram_addr_a),
        .data_image0(data_image0), .data_image1(data_image1),
        .data_image2(data_image2), .data_image3(data_image3),
        .we_image0(we_image0), .we_image1(we_image1),
        .we_image2(we_image2), .we_image3(we_image3),
        .conv_ram_addr_a(conv_ram_addr_a), .data_conv(data_conv), .we_conv(we_conv),
        .dense_ram_addr_a(dense_ram_addr_a), .data_dense(data_dense), .we_dense(we_dense),
        .denseb_ram_addr_a(denseb_ram_addr_a), .data_denseb(data_denseb), .we_denseb(we_denseb),
        .busy(busy), .done(done), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;
    int unsigned we_count = 0;
    int unsigned last_we_cyc = 0;

    // port: 0..3 image banks, 4 conv, 5 dense, 6 denseb
    typedef struct {
        int unsigned port;
        int unsigned addr;
        int unsigned data;
        int unsigned cyc;
    } wr_t;

    wr_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every we pulse must match the oldest predicted write.
    always @(negedge clk) begin
        int unsigned nwe;
        int unsigned port, addr, data;
        wr_t e;
        nwe = int'(we_image0) + int'(we_image1) + int'(we_image2) + int'(we_image3)
            + int'(we_conv) + int'(we_dense) + int'(we_denseb);
        port = 0; addr = 0; data = 0;
        if (nwe != 0) begin
            if (we_image0)      begin port = 0; addr = image_ram_addr_a; data = data_image0; end
            else if (we_image1) begin port = 1; addr = image_ram_addr_a; data = data_image1; end
            else if (we_image2) begin port = 2; addr = image_ram_addr_a; data = data_image2; end
            else if (we_image3) begin port = 3; addr = image_ram_addr_a; data = data_image3; end
            else if (we_conv)   begin port = 4; addr = conv_ram_addr_a;  data = data_conv;   end
            else if (we_dense)  begin port = 5; addr = dense_ram_addr_a; data = data_dense;  end
            else                begin port = 6; addr = denseb_ram_addr_a; data = data_denseb; end
            we_count++;
            last_we_cyc = cyc;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got port=%0d addr=%0h data=%0h cyc=%0d, expected no write",
                         port, addr, data, cyc);
            end else begin
                e = sb.pop_front();
                if (port !== e.port || addr !== e.addr || data !== e.data || cyc !== e.cyc || nwe !== 1) begin
                    bad++;
                    $display("FAIL write: got port=%0d addr=%0h data=%0h cyc=%0d nwe=%0d, expected port=%0d addr=%0h data=%0h cyc=%0d nwe=1",
                             port, addr, data, cyc, nwe, e.port, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [1:0] t, input int unsigned len);
        int unsigned w;
        cmd_valid  = 1'b1;
        cmd_target = t;
        cmd_len    = len[15:0];
        w = 0;
        while (cmd_ready !== 1'b1 && w < 200) begin
            step();
            w++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL cmd_accept: cmd_ready=%b, required 1 within 200 cycles", cmd_ready);
        end
        we_count = 0;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic run_bytes(input logic [1:0] t, input int unsigned n_accept,
                             input bit toggle, input logic [7:0] base);
        int unsigned k, ph, guard;
        wr_t e;
        k = 0; ph = 0; guard = 0;
        while (k < n_accept && guard < 70000) begin
            if (toggle && ph[0]) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = base + k[7:0];
            end
            ph++;
            total++;
            if (in_ready !== 1'b1 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL load_handshake: in_ready=%b cmd_ready=%b busy=%b, required 1 0 1 (byte %0d)",
                         in_ready, cmd_ready, busy, k);
            end
            if (in_valid && in_ready) begin
                if (t == 2'd0) begin
                    e.port = k % 4;
                    e.addr = (k / 4) % 1024;
                end else begin
                    e.port = 3 + int'(t);
                    e.addr = k % 32768;
                end
                e.data = (int'(base) + k) % 256;
                e.cyc  = cyc + 1;
                sb.push_back(e);
                k++;
            end
            step();
            guard++;
        end
        total++;
        if (k != n_accept) begin
            bad++;
            $display("FAIL byte_timeout: accepted=%0d, required %0d", k, n_accept);
        end
        if (!toggle) in_data = base + k[7:0];
    endtask

    task automatic check_done(input int unsigned len_eff, input logic exp_err);
        total++;
        if (done !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL done_cycle: done=%b busy=%b cmd_ready=%b in_ready=%b, required 1 1 0 0",
                     done, busy, cmd_ready, in_ready);
        end
        total++;
        if (sb.size() != 0 || we_count != len_eff) begin
            bad++;
            $display("FAIL write_count: pending=%0d we_pulses=%0d, required 0 and %0d",
                     sb.size(), we_count, len_eff);
        end
        if (len_eff > 0) begin
            total++;
            if (last_we_cyc != cyc) begin
                bad++;
                $display("FAIL done_align: last we cycle=%0d, required done cycle %0d", last_we_cyc, cyc);
            end
        end
        total++;
        if (len_err !== exp_err) begin
            bad++;
            $display("FAIL len_err: got %b, required %b", len_err, exp_err);
        end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_after: done=%b busy=%b cmd_ready=%b in_ready=%b, required 0 0 1 0",
                     done, busy, cmd_ready, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step(); step();
        total++;
        if (cmd_ready !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || len_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: cmd_ready=%b in_ready=%b busy=%b done=%b len_err=%b, required 1 0 0 0 0",
                     cmd_ready, in_ready, busy, done, len_err);
        end
        total++;
        if ({we_image0, we_image1, we_image2, we_image3, we_conv, we_dense, we_denseb} !== 7'b0 ||
            image_ram_addr_a !== '0 || conv_ram_addr_a !== '0 || dense_ram_addr_a !== '0 ||
            denseb_ram_addr_a !== '0 ||
            {data_image0, data_image1, data_image2, data_image3, data_conv, data_dense, data_denseb} !== 56'h0) begin
            bad++;
            $display("FAIL reset_ports: some write port nonzero (img_addr=%0h conv_addr=%0h d0=%0h), required all 0",
                     image_ram_addr_a, conv_ram_addr_a, data_image0);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_image();
        issue_cmd(2'd0, 8);
        run_bytes(2'd0, 8, 1'b0, 8'h10);
        check_done(8, 1'b0);
        in_valid = 1'b0;
        total++;
        if (data_image2 !== 8'h16 || image_ram_addr_a !== 10'd1) begin
            bad++;
            $display("FAIL image_hold: data_image2=%0h addr=%0h, required 16 and 1", data_image2, image_ram_addr_a);
        end
    endtask

    task automatic test_conv_toggle();
        issue_cmd(2'd1, 3);
        run_bytes(2'd1, 3, 1'b1, 8'hA0);
        check_done(3, 1'b0);
        in_valid = 1'b0;
    endtask

    task automatic test_dense_overflow();
        issue_cmd(2'd2, 40000);
        total++;
        if (len_err !== 1'b1) begin
            bad++;
            $display("FAIL len_err_set: got %b, required 1", len_err);
        end
        run_bytes(2'd2, 32768, 1'b0, 8'h00);
        check_done(32768, 1'b1);
        in_valid = 1'b0;
        total++;
        if (dense_ram_addr_a !== 15'h7FFF || len_err !== 1'b1) begin
            bad++;
            $display("FAIL dense_last: addr=%0h len_err=%b, required 7fff and 1", dense_ram_addr_a, len_err);
        end
    endtask

    task automatic test_zero_len();
        issue_cmd(2'd3, 0);
        check_done(0, 1'b0);
    endtask

    task automatic test_reset_mid();
        issue_cmd(2'd0, 10);
        run_bytes(2'd0, 5, 1'b0, 8'h30);
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        total++;
        if ({we_image0, we_image1, we_image2, we_image3, we_conv, we_dense, we_denseb} !== 7'b0 ||
            busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL reset_mid: we_any=%b busy=%b cmd_ready=%b done=%b pending=%0d, required 0 0 1 0 0",
                     we_image0 | we_image1 | we_image2 | we_image3 | we_conv | we_dense | we_denseb,
                     busy, cmd_ready, done, sb.size());
        end
        reset = 1'b1;
        step();
        issue_cmd(2'd1, 2);
        run_bytes(2'd1, 2, 1'b0, 8'h55);
        check_done(2, 1'b0);
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        issue_cmd(2'd1, 4);
        cmd_valid  = 1'b1;
        cmd_target = 2'd2;
        cmd_len    = 16'd2;
        run_bytes(2'd1, 4, 1'b0, 8'hC0);
        check_done(4, 1'b0);
        issue_cmd(2'd2, 2);
        run_bytes(2'd2, 2, 1'b0, 8'h77);
        check_done(2, 1'b0);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_image();
        test_conv_toggle();
        test_dense_overflow();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        step(); step();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover: pending writes=%0d, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
